cache_sa_wb: RTL

- Clocked, parametrised set-associative write-back, write-allocate cache between the CPU request port and main_mem-style word memory.
- Successor to the single-configuration direct-mapped cache: generalises sets, ways, block size and widths.
- Adds a synchronous valid/ready handshake on both sides, LRU replacement, and byte-granular reads and writes.
- One outstanding CPU request at a time; memory traffic is word-wide, one beat per handshake.

---
 rtl/cache_sa_wb.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_sa_wb.sv
// cache_sa_wb: parametrised set-associative, write-back, write-allocate cache.
// A CPU port with a valid/ready handshake sits in front of a word-wide memory
// port that moves one beat per mem_req/mem_done handshake. Only one CPU request
// is in flight at a time. Replacement prefers an invalid way, then the LRU way.
// SETS and WPB are expected to be at least 2 so that index and word-offset
// fields have non-zero width.
module cache_sa_wb #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int SETS   = 4,
  parameter int WAYS   = 2,
  parameter int WPB    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_byte,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done
);

  localparam int OFF_W = $clog2(WPB);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WBACK, S_REFILL} state_t;

  state_t r_state, w_state_nxt;

  // Latched CPU request
  logic              r_req_we, r_req_byte;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_req_wdata;
  logic              r_missed;

  // Line state and storage
  logic [DATA_W-1:0] r_data  [WAYS][SETS][WPB];
  logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
  logic [SETS-1:0]   r_valid [WAYS];
  logic [SETS-1:0]   r_dirty [WAYS];
  logic [SETS-1:0]   r_lru;

  // Miss handling
  logic              r_victim;
  logic [OFF_W-1:0]  r_beat;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  // CPU response
  logic              r_cpu_ready, r_hit;
  logic [DATA_W-1:0] r_cpu_rdata;

  // Request address fields
  logic [TAG_W-1:0] w_req_tag;
  logic [IDX_W-1:0] w_req_idx;
  logic [OFF_W-1:0] w_req_off;
  logic [1:0]       w_req_bsel;

  assign w_req_tag  = r_req_addr[ADDR_W-1 -: TAG_W];
  assign w_req_idx  = r_req_addr[OFF_W+2 +: IDX_W];
  assign w_req_off  = r_req_addr[2 +: OFF_W];
  assign w_req_bsel = r_req_addr[1:0];

  logic              w_hit, w_hit_way, w_victim;
  logic [DATA_W-1:0] w_hit_word, w_rd_val, w_wr_word;
  logic [7:0]        w_rd_byte;
  logic              w_accept, w_complete, w_miss, w_issue, w_fire, w_beat_last;

  // Tag compare across ways; lowest way wins if several could match
  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w][w_req_idx] && (r_tag[w][w_req_idx] == w_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = 1'(w);
      end
    end
  end

  // Victim choice: first invalid way, otherwise the LRU way
  always_comb begin
    w_victim = 1'b0;
    if (WAYS == 2) begin
      if (!r_valid[0][w_req_idx])             w_victim = 1'b0;
      else if (!r_valid[WAYS-1][w_req_idx])   w_victim = 1'b1;
      else                                    w_victim = r_lru[w_req_idx];
    end
  end

  // Read formatting (sign-extended byte) and write merge of the hit word
  always_comb begin
    w_hit_word = r_data[w_hit_way][w_req_idx][w_req_off];
    w_rd_byte  = w_hit_word[{w_req_bsel, 3'b000} +: 8];
    w_rd_val   = r_req_byte ? {{(DATA_W-8){w_rd_byte[7]}}, w_rd_byte} : w_hit_word;
    w_wr_word  = r_req_wdata;
    if (r_req_byte) begin
      w_wr_word = w_hit_word;
      w_wr_word[{w_req_bsel, 3'b000} +: 8] = r_req_wdata[7:0];
    end
  end

  assign w_fire      = r_mem_req && mem_done;
  assign w_beat_last = (r_beat == OFF_W'(WPB - 1));

  // Next-state logic and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_miss      = 1'b0;
    w_issue     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_accept = cpu_req;
        if (cpu_req) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_miss = 1'b1;
          if (r_valid[w_victim][w_req_idx] && r_dirty[w_victim][w_req_idx])
            w_state_nxt = S_WBACK;
          else
            w_state_nxt = S_REFILL;
        end
      end
      S_WBACK: begin
        w_issue = !r_mem_req;
        if (w_fire && w_beat_last) w_state_nxt = S_REFILL;
      end
      S_REFILL: begin
        w_issue = !r_mem_req;
        if (w_fire && w_beat_last) w_state_nxt = S_LOOKUP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Request latch, line status, beat sequencing and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_req_we    <= 1'b0;
      r_req_byte  <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_missed    <= 1'b0;
      r_victim    <= 1'b0;
      r_beat      <= '0;
      r_lru       <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_ready <= 1'b0;
      r_hit       <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_req_we    <= cpu_we;
        r_req_byte  <= cpu_byte;
        r_req_addr  <= cpu_addr;
        r_req_wdata <= cpu_wdata;
        r_missed    <= 1'b0;
      end

      r_cpu_ready <= w_complete;
      r_hit       <= w_complete && !r_missed;
      if (w_complete) begin
        if (!r_req_we) r_cpu_rdata <= w_rd_val;
        else           r_dirty[w_hit_way][w_req_idx] <= 1'b1;
        if (WAYS == 2) r_lru[w_req_idx] <= ~w_hit_way;
      end

      if (w_miss) begin
        r_missed <= 1'b1;
        r_victim <= w_victim;
        r_beat   <= '0;
        // A clean victim is overwritten straight away, so it stops being valid now
        if (!(r_valid[w_victim][w_req_idx] && r_dirty[w_victim][w_req_idx]))
          r_valid[w_victim][w_req_idx] <= 1'b0;
      end

      if (w_issue) begin
        r_mem_req <= 1'b1;
        if (r_state == S_WBACK) begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= {r_tag[r_victim][w_req_idx], w_req_idx, r_beat, 2'b00};
          r_mem_wdata <= r_data[r_victim][w_req_idx][r_beat];
        end else begin
          r_mem_we    <= 1'b0;
          r_mem_addr  <= {w_req_tag, w_req_idx, r_beat, 2'b00};
        end
      end

      if (w_fire) begin
        r_mem_req <= 1'b0;
        r_beat    <= r_beat + 1'b1;
        if (w_beat_last && (r_state == S_WBACK)) begin
          r_dirty[r_victim][w_req_idx] <= 1'b0;
          r_valid[r_victim][w_req_idx] <= 1'b0;
        end
        if (w_beat_last && (r_state == S_REFILL)) begin
          r_valid[r_victim][w_req_idx] <= 1'b1;
          r_dirty[r_victim][w_req_idx] <= 1'b0;
        end
      end
    end
  end

  // Data and tag storage: refill beats and CPU write hits
  // NOTE: the arrays are deliberately not reset; valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if ((r_state == S_REFILL) && w_fire) begin
        r_data[r_victim][w_req_idx][r_beat] <= mem_rdata;
        if (w_beat_last) r_tag[r_victim][w_req_idx] <= w_req_tag;
      end
      if (w_complete && r_req_we)
        r_data[w_hit_way][w_req_idx][w_req_off] <= w_wr_word;
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ready = r_cpu_ready;
  assign hit       = r_hit;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
